zap_tlb_assoc: RTL

Parametrised N-way set-associative TLB array for one page-size class. It is the successor to the direct-mapped, single-cycle-clear TLB memories and is instantiated once per page class under the TLB management unit.
- Adds configurable ways, per-set round-robin replacement, duplicate suppression, and single-VA invalidate.
- Adds a multi-cycle invalidate-all sweep, so deep TLBs do not need single-cycle clearing flops.
- Lookup is 1-cycle registered; the tlb_check/fsm logic consumes the lookup output.

---
 rtl/zap_tlb_pkg.sv | 29 ++
 rtl/zap_tlb_assoc_if.sv | 26 ++
 rtl/zap_tlb_victim_sel.sv | 41 ++++
 rtl/zap_tlb_assoc.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/zap_tlb_pkg.sv
// Shared types and address-decode helpers for the set-associative TLB arrays.
package zap_tlb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } tlb_sweep_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Callers truncate the 32-bit results to IDX_W / TAG_W.
  function automatic logic [31:0] idx_of(input logic [31:0] va, input int page_shift,
                                         input int idx_w);
    return (va >> page_shift) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] va, input int page_shift,
                                         input int idx_w);
    return va >> (page_shift + idx_w);
  endfunction

endpackage

// File: rtl/zap_tlb_assoc_if.sv
// Lookup, fill and invalidate signals of one TLB page-class array.
interface zap_tlb_assoc_if #(
  parameter int DATA_W = 32
);
  logic              i_clken;
  logic [31:0]       i_rd_va;
  logic              o_rdav;
  logic [DATA_W-1:0] o_rdata;
  logic              i_wen;
  logic [31:0]       i_wva;
  logic [DATA_W-1:0] i_wdata;
  logic              i_inv_all;
  logic              i_inv_va_en;
  logic [31:0]       i_inv_va;
  logic              o_busy;

  modport master (
    output i_clken, i_rd_va, i_wen, i_wva, i_wdata, i_inv_all, i_inv_va_en, i_inv_va,
    input  o_rdav, o_rdata, o_busy
  );

  modport slave (
    input  i_clken, i_rd_va, i_wen, i_wva, i_wdata, i_inv_all, i_inv_va_en, i_inv_va,
    output o_rdav, o_rdata, o_busy
  );
endinterface

// File: rtl/zap_tlb_victim_sel.sv
// Way choice for a fill: matching way, else lowest free way, else round-robin victim.
module zap_tlb_victim_sel
  import zap_tlb_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int PTR_W = max4(1, $clog2(WAYS), 1, 1)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  match,
  input  logic [PTR_W-1:0] ptr,
  output logic [WAYS-1:0]  way_oh,
  output logic             advance
);

  logic [WAYS-1:0] hit_vec;
  logic [WAYS-1:0] free_vec;
  logic [WAYS-1:0] free_low;
  logic [WAYS-1:0] rr_vec;

  assign hit_vec  = valid & match;
  assign free_vec = ~valid;
  // Isolate the lowest set bit of the free vector.
  assign free_low = free_vec & (~free_vec + WAYS'(1));

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_rr
    assign rr_vec[gi] = (ptr == PTR_W'(gi));
  end

  always_comb begin
    way_oh  = rr_vec;
    advance = 1'b1;
    if (|hit_vec) begin
      way_oh  = hit_vec;
      advance = 1'b0;
    end else if (|free_vec) begin
      way_oh  = free_low;
      advance = 1'b0;
    end
  end

endmodule

// File: rtl/zap_tlb_assoc.sv
// N-way set-associative TLB array: registered lookup, RR fill, VA invalidate and
// a one-set-per-cycle invalidate-all sweep.
module zap_tlb_assoc
  import zap_tlb_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int PAGE_SHIFT = 12,
  parameter int DATA_W     = 32
) (
  input logic            i_clk,
  input logic            i_reset_n,
  zap_tlb_assoc_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - PAGE_SHIFT - IDX_W;
  localparam int PTR_W = max4(1, $clog2(WAYS), 1, 1);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_SWEEP = SWEEP;

  logic [IDX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       m_va;
  logic [IDX_W-1:0]  m_idx;
  logic [TAG_W-1:0]  m_tag;

  logic [WAYS-1:0]   valid_reg [SETS];
  logic [PTR_W-1:0]  rr_reg    [SETS];
  logic [0:0]        state_reg, state_next;
  logic [IDX_W-1:0]  cnt_reg, cnt_next;
  logic              rdav_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [WAYS-1:0]   rd_match, rd_hit, m_match;
  logic [DATA_W-1:0] rd_data_way [WAYS];
  logic [DATA_W-1:0] rd_data;
  logic [WAYS-1:0]   fill_oh;
  logic              fill_adv;
  logic [PTR_W-1:0]  rr_adv;
  logic              sweeping, inv_en, fill_en;

  assign sweeping = (state_reg == ST_SWEEP);
  assign inv_en   = !sweeping && !bus.i_inv_all && bus.i_inv_va_en;
  assign fill_en  = !sweeping && !bus.i_inv_all && !bus.i_inv_va_en && bus.i_wen;

  // Fill and single invalidate are mutually exclusive, so they share one modify port.
  assign m_va   = bus.i_inv_va_en ? bus.i_inv_va : bus.i_wva;
  assign rd_idx = IDX_W'(idx_of(bus.i_rd_va, PAGE_SHIFT, IDX_W));
  assign rd_tag = TAG_W'(tag_of(bus.i_rd_va, PAGE_SHIFT, IDX_W));
  assign m_idx  = IDX_W'(idx_of(m_va, PAGE_SHIFT, IDX_W));
  assign m_tag  = TAG_W'(tag_of(m_va, PAGE_SHIFT, IDX_W));

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [DATA_W-1:0] data_mem [SETS];

    always_ff @(posedge i_clk) begin
      if (fill_en && fill_oh[gi]) begin
        tag_mem[m_idx]  <= m_tag;
        data_mem[m_idx] <= bus.i_wdata;
      end
    end

    assign rd_match[gi]    = (tag_mem[rd_idx] == rd_tag);
    assign m_match[gi]     = (tag_mem[m_idx] == m_tag);
    assign rd_data_way[gi] = data_mem[rd_idx];
  end

  assign rd_hit = valid_reg[rd_idx] & rd_match;

  always_comb begin
    rd_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_hit[w]) rd_data = rd_data | rd_data_way[w];
    end
  end

  zap_tlb_victim_sel #(
    .WAYS  (WAYS),
    .PTR_W (PTR_W)
  ) u_victim (
    .valid   (valid_reg[m_idx]),
    .match   (m_match),
    .ptr     (rr_reg[m_idx]),
    .way_oh  (fill_oh),
    .advance (fill_adv)
  );

  assign rr_adv = (rr_reg[m_idx] == PTR_W'(WAYS - 1)) ? '0 : rr_reg[m_idx] + PTR_W'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (bus.i_inv_all) begin
      state_next = ST_SWEEP;
      cnt_next   = '0;
    end else if (sweeping) begin
      cnt_next = cnt_reg + IDX_W'(1);
      if (cnt_reg == IDX_W'(SETS - 1)) state_next = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        rr_reg[s]    <= '0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!bus.i_inv_all) begin
        if (sweeping) begin
          valid_reg[cnt_reg] <= '0;
          rr_reg[cnt_reg]    <= '0;
        end else if (inv_en) begin
          valid_reg[m_idx] <= valid_reg[m_idx] & ~m_match;
        end else if (fill_en) begin
          valid_reg[m_idx] <= valid_reg[m_idx] | fill_oh;
          if (fill_adv) rr_reg[m_idx] <= rr_adv;
        end
      end
    end
  end

  // Lookups issued mid-sweep may see sets not yet cleared, so they register as misses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rdav_reg  <= 1'b0;
      rdata_reg <= '0;
    end else if (bus.i_clken) begin
      rdav_reg  <= !sweeping && (|rd_hit);
      rdata_reg <= sweeping ? '0 : rd_data;
    end
  end

  assign bus.o_rdav  = rdav_reg && !sweeping;
  assign bus.o_rdata = sweeping ? '0 : rdata_reg;
  assign bus.o_busy  = sweeping;

  a_single_hit : assert property (@(posedge i_clk) disable iff (!i_reset_n) $onehot0(rd_hit));

endmodule
